game_turn_ctrl: RTL and testbench

- Turn sequencer for the two-player game timer.
- Owns both players' countdown registers in 0.1 s units and decides which one runs on each 10 Hz tick.
- Handles start, hand-over, pause, resign and timeout, and produces loser flags and low-time warnings.
- Sits between the debounced keypad strobes and the display, LED and buzzer logic, which consume time_a, time_b and the flags.

---
 rtl/game_timer_pkg.sv | 24 ++
 rtl/player_clock.sv | 74 +++++++
 rtl/game_turn_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_game_turn_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/game_timer_pkg.sv
// Shared definitions for the two-player game timer: time width, default
// time controls, warning threshold and the turn-sequencer state encoding.
package game_timer_pkg;

  localparam int TW             = 10;
  localparam int TIME_SHORT_DEF = 100;
  localparam int TIME_LONG_DEF  = 300;
  localparam int WARN_TH_DEF    = 50;
  localparam int INC_DEF        = 20;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN_A = 3'd1,
    RUN_B = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } state_e;

  // True when a remaining time sits in the low-time band 1..th.
  function automatic logic in_warn_band(input logic [TW-1:0] t, input logic [TW-1:0] th);
    return (t != '0) && (t <= th);
  endfunction

endpackage

// File: rtl/player_clock.sv
// One player's countdown register in tenths of a second.
// Load has priority over counting; the decrement never goes below zero.
// With FISCHER_INC_EN defined, inc_en adds INC after any same-cycle
// decrement, saturating at the all-ones value.
module player_clock
  import game_timer_pkg::*;
#(
  parameter logic [TW-1:0] RESET_VAL = TW'(TIME_SHORT_DEF),
  parameter int            INC       = INC_DEF
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load_en,
  input  logic [TW-1:0] load_val,
  input  logic          dec_en,
  input  logic          inc_en,
  output logic [TW-1:0] count,
  output logic [TW-1:0] count_next,
  output logic          zero_next
);

  logic [TW-1:0] count_q, count_d;
  logic [TW-1:0] after_dec;

`ifdef FISCHER_INC_EN
  localparam logic [TW:0] INC_W = (TW+1)'(INC);
  logic [TW:0] inc_sum;

  // Next count: reload, else decrement then optional saturating increment.
  always_comb begin
    after_dec = count_q;
    if (dec_en && (count_q != '0)) begin
      after_dec = count_q - 1'b1;
    end
    inc_sum = {1'b0, after_dec} + INC_W;
    count_d = after_dec;
    if (inc_en) begin
      count_d = inc_sum[TW] ? '1 : inc_sum[TW-1:0];
    end
    if (load_en) begin
      count_d = load_val;
    end
  end
`else
  logic unused_inc;
  assign unused_inc = inc_en ^ (INC != 0);

  // Next count: reload, else decrement when enabled and non-zero.
  always_comb begin
    after_dec = count_q;
    if (dec_en && (count_q != '0)) begin
      after_dec = count_q - 1'b1;
    end
    count_d = after_dec;
    if (load_en) begin
      count_d = load_val;
    end
  end
`endif

  // Count register, restarting from the short time control on reset.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;
  assign zero_next  = (count_q == TW'(1));

endmodule

// File: rtl/game_turn_ctrl.sv
// Turn sequencer for the two-player game timer. Decides which player's
// clock runs on each 10 Hz tick and handles start, hand-over, pause,
// resign, timeout and new game. Optional macro FISCHER_INC_EN gives the
// player handing over a per-move increment of INC tenths.
module game_turn_ctrl
  import game_timer_pkg::*;
#(
  parameter int TIME_SHORT = TIME_SHORT_DEF,
  parameter int TIME_LONG  = TIME_LONG_DEF,
  parameter int WARN_TH    = WARN_TH_DEF,
  parameter int INC        = INC_DEF
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          tick,
  input  logic          mode,
  input  logic          go_a,
  input  logic          go_b,
  input  logic          pause,
  input  logic          resign_a,
  input  logic          resign_b,
  input  logic          new_game,
  output logic [TW-1:0] time_a,
  output logic [TW-1:0] time_b,
  output logic          run_a,
  output logic          run_b,
  output logic          lost_a,
  output logic          lost_b,
  output logic          warn,
  output logic [2:0]    st
);

  if ((TIME_LONG >= (1 << TW)) || ((TIME_LONG + INC) >= (1 << TW))) begin : g_bad_cfg
    $error("game_turn_ctrl: TIME_LONG and TIME_LONG+INC must fit in TW bits");
  end

  state_e        state_q, state_d;
  logic          side_q, side_d;
  logic          lost_a_q, lost_a_d;
  logic          lost_b_q, lost_b_d;
  logic          warn_q, warn_d;

  logic          load_en;
  logic [TW-1:0] load_val;
  logic          dec_a, dec_b, inc_a, inc_b;
  logic [TW-1:0] cnt_a, cnt_b, cnt_a_next, cnt_b_next;
  logic          zero_next_a, zero_next_b;

  assign load_val = mode ? TW'(TIME_LONG) : TW'(TIME_SHORT);

  player_clock #(.RESET_VAL(TW'(TIME_SHORT)), .INC(INC)) u_clock_a (
    .clk        (clk),
    .clr        (clr),
    .load_en    (load_en),
    .load_val   (load_val),
    .dec_en     (dec_a),
    .inc_en     (inc_a),
    .count      (cnt_a),
    .count_next (cnt_a_next),
    .zero_next  (zero_next_a)
  );

  player_clock #(.RESET_VAL(TW'(TIME_SHORT)), .INC(INC)) u_clock_b (
    .clk        (clk),
    .clr        (clr),
    .load_en    (load_en),
    .load_val   (load_val),
    .dec_en     (dec_b),
    .inc_en     (inc_b),
    .count      (cnt_b),
    .count_next (cnt_b_next),
    .zero_next  (zero_next_b)
  );

  // Next state, flags and counter controls; one prioritised event per cycle.
  always_comb begin
    state_d  = state_q;
    side_d   = side_q;
    lost_a_d = lost_a_q;
    lost_b_d = lost_b_q;
    load_en  = 1'b0;
    dec_a    = 1'b0;
    dec_b    = 1'b0;
    inc_a    = 1'b0;
    inc_b    = 1'b0;

    if (new_game) begin
      state_d  = IDLE;
      lost_a_d = 1'b0;
      lost_b_d = 1'b0;
      load_en  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          load_en = 1'b1;
          if (go_a && !go_b) begin
            state_d = RUN_A;
          end else if (go_b && !go_a) begin
            state_d = RUN_B;
          end
        end

        RUN_A: begin
          if (resign_a || resign_b) begin
            lost_a_d = lost_a_q | resign_a;
            lost_b_d = lost_b_q | resign_b;
            state_d  = OVER;
          end else if (tick && zero_next_a) begin
            dec_a    = 1'b1;
            lost_a_d = 1'b1;
            state_d  = OVER;
          end else if (pause) begin
            side_d  = 1'b0;
            state_d = PAUSE;
          end else if (go_b) begin
            dec_a   = tick;
            inc_a   = 1'b1;
            state_d = RUN_B;
          end else begin
            dec_a = tick;
          end
        end

        RUN_B: begin
          if (resign_a || resign_b) begin
            lost_a_d = lost_a_q | resign_a;
            lost_b_d = lost_b_q | resign_b;
            state_d  = OVER;
          end else if (tick && zero_next_b) begin
            dec_b    = 1'b1;
            lost_b_d = 1'b1;
            state_d  = OVER;
          end else if (pause) begin
            side_d  = 1'b1;
            state_d = PAUSE;
          end else if (go_a) begin
            dec_b   = tick;
            inc_b   = 1'b1;
            state_d = RUN_A;
          end else begin
            dec_b = tick;
          end
        end

        PAUSE: begin
          if (resign_a || resign_b) begin
            lost_a_d = lost_a_q | resign_a;
            lost_b_d = lost_b_q | resign_b;
            state_d  = OVER;
          end else if (pause) begin
            state_d = side_q ? RUN_B : RUN_A;
          end
        end

        OVER: begin
          state_d = OVER;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Low-time warning follows the side that will be running after this edge.
  always_comb begin
    warn_d = ((state_d == RUN_A) && in_warn_band(cnt_a_next, TW'(WARN_TH))) ||
             ((state_d == RUN_B) && in_warn_band(cnt_b_next, TW'(WARN_TH)));
  end

  // State, saved pause side, loser flags and warning registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      side_q   <= 1'b0;
      lost_a_q <= 1'b0;
      lost_b_q <= 1'b0;
      warn_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      side_q   <= side_d;
      lost_a_q <= lost_a_d;
      lost_b_q <= lost_b_d;
      warn_q   <= warn_d;
    end
  end

  assign time_a = cnt_a;
  assign time_b = cnt_b;
  assign run_a  = (state_q == RUN_A);
  assign run_b  = (state_q == RUN_B);
  assign lost_a = lost_a_q;
  assign lost_b = lost_b_q;
  assign warn   = warn_q;
  assign st     = state_q;

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Scoreboard bench for game_turn_ctrl: the driver pushes hand-computed
// expectations after each edge, a monitor pops and compares on the
// following falling edge.
module tb_game_turn_ctrl;

  localparam logic [6:0] TK = 7'b0000001;
  localparam logic [6:0] GA = 7'b0000010;
  localparam logic [6:0] GB = 7'b0000100;
  localparam logic [6:0] PS = 7'b0001000;
  localparam logic [6:0] RA = 7'b0010000;
  localparam logic [6:0] RB = 7'b0100000;
  localparam logic [6:0] NG = 7'b1000000;

`ifdef FISCHER_INC_EN
  localparam int INC_TB = 20;
`else
  localparam int INC_TB = 0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       tick = 1'b0, mode = 1'b0, go_a = 1'b0, go_b = 1'b0, pause = 1'b0;
  logic       resign_a = 1'b0, resign_b = 1'b0, new_game = 1'b0;
  logic [9:0] time_a, time_b;
  logic       run_a, run_b, lost_a, lost_b, warn;
  logic [2:0] st;

  typedef struct packed {
    logic [9:0] ta;
    logic [9:0] tb;
    logic       ra;
    logic       rb;
    logic       la;
    logic       lb;
    logic       w;
    logic [2:0] st;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  int    ta_hold, tb_hold;

  game_turn_ctrl dut (
    .clk      (clk),
    .clr      (clr),
    .tick     (tick),
    .mode     (mode),
    .go_a     (go_a),
    .go_b     (go_b),
    .pause    (pause),
    .resign_a (resign_a),
    .resign_b (resign_b),
    .new_game (new_game),
    .time_a   (time_a),
    .time_b   (time_b),
    .run_a    (run_a),
    .run_b    (run_b),
    .lost_a   (lost_a),
    .lost_b   (lost_b),
    .warn     (warn),
    .st       (st)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int ta, input int tb, input bit ra, input bit rb,
                              input bit la, input bit lb, input bit w, input int s);
    exp_t e;
    e.ta = 10'(ta);
    e.tb = 10'(tb);
    e.ra = ra;
    e.rb = rb;
    e.la = la;
    e.lb = lb;
    e.w  = w;
    e.st = 3'(s);
    return e;
  endfunction

  function automatic bit wv(input int t);
    return (t >= 1) && (t <= 50);
  endfunction

  task automatic checkOutput(input exp_t e, input string name);
    exp_t got;
    got = {time_a, time_b, run_a, run_b, lost_a, lost_b, warn, st};
    checks++;
    if (got !== e) begin
      errors++;
      $display("[TB] FAIL %s: got ta=%0d tb=%0d run=%b%b lost=%b%b warn=%b st=%0d, expected ta=%0d tb=%0d run=%b%b lost=%b%b warn=%b st=%0d",
               name, got.ta, got.tb, got.ra, got.rb, got.la, got.lb, got.w, got.st,
               e.ta, e.tb, e.ra, e.rb, e.la, e.lb, e.w, e.st);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] s, input bit chk, input exp_t e, input string name);
    {new_game, resign_b, resign_a, pause, go_b, go_a, tick} = s;
    @(posedge clk);
    #1;
    {new_game, resign_b, resign_a, pause, go_b, go_a, tick} = '0;
    if (chk) begin
      exp_q.push_back(e);
      name_q.push_back(name);
    end
  endtask

  // Monitor: compares the oldest pending expectation on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        checkOutput(exp_q.pop_front(), name_q.pop_front());
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state while clr is held low.
    #1;
    exp_q.push_back(mk(100, 100, 0, 0, 0, 0, 0, 0));
    name_q.push_back("reset_state");
    @(negedge clk);
    #2 clr = 1'b1;

    // Simultaneous go strobes are ignored in IDLE.
    applyStimulus(GA | GB, 1, mk(100, 100, 0, 0, 0, 0, 0, 0), "idle_both_go");

    // Load and timeout with the short time control.
    applyStimulus(GA, 1, mk(100, 100, 1, 0, 0, 0, 0, 1), "start_a");
    for (int i = 1; i <= 100; i++) begin
      if (i < 100) applyStimulus(TK, 1, mk(100 - i, 100, 1, 0, 0, 0, wv(100 - i), 1), "count_a");
      else         applyStimulus(TK, 1, mk(0, 100, 0, 0, 1, 0, 0, 4), "timeout_a");
    end
    applyStimulus(TK | GB, 1, mk(0, 100, 0, 0, 1, 0, 0, 4), "over_frozen");
    applyStimulus(NG, 1, mk(100, 100, 0, 0, 0, 0, 0, 0), "new_game_after_timeout");

    // Hand-over coincident with a tick, long time control.
    mode = 1'b1;
    applyStimulus('0, 1, mk(300, 300, 0, 0, 0, 0, 0, 0), "idle_reload_long");
    applyStimulus(GA, 1, mk(300, 300, 1, 0, 0, 0, 0, 1), "start_a_long");
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(TK, 1, mk(300 - i, 300, 1, 0, 0, 0, 0, 1), "count_a_long");
    end
    ta_hold = 294 + INC_TB;
    applyStimulus(TK | GB, 1, mk(ta_hold, 300, 0, 1, 0, 0, 0, 2), "handover_tick");

    // Pause and resume in RUN_B at 250.
    for (int i = 1; i <= 50; i++) begin
      applyStimulus(TK, 1, mk(ta_hold, 300 - i, 0, 1, 0, 0, 0, 2), "count_b");
    end
    applyStimulus(PS, 1, mk(ta_hold, 250, 0, 0, 0, 0, 0, 3), "pause_b");
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(TK, 1, mk(ta_hold, 250, 0, 0, 0, 0, 0, 3), "pause_tick");
    end
    applyStimulus(GA, 1, mk(ta_hold, 250, 0, 0, 0, 0, 0, 3), "pause_go_a");
    applyStimulus(PS, 1, mk(ta_hold, 250, 0, 1, 0, 0, 0, 2), "resume_b");
    applyStimulus(TK, 1, mk(ta_hold, 249, 0, 1, 0, 0, 0, 2), "resume_tick");

    // Hand-over back to A, then a draw by double resign.
    tb_hold = 249 + INC_TB;
    applyStimulus(GA, 1, mk(ta_hold, tb_hold, 1, 0, 0, 0, 0, 1), "handover_to_a");
    applyStimulus(RA | RB, 1, mk(ta_hold, tb_hold, 0, 0, 1, 1, 0, 4), "draw");
    applyStimulus(TK, 1, mk(ta_hold, tb_hold, 0, 0, 1, 1, 0, 4), "draw_tick");
    applyStimulus(GA, 1, mk(ta_hold, tb_hold, 0, 0, 1, 1, 0, 4), "draw_go_a");
    applyStimulus(GB | TK, 1, mk(ta_hold, tb_hold, 0, 0, 1, 1, 0, 4), "draw_go_b");
    applyStimulus(NG, 1, mk(300, 300, 0, 0, 0, 0, 0, 0), "draw_new_game");
    mode = 1'b0;
    applyStimulus('0, 1, mk(100, 100, 0, 0, 0, 0, 0, 0), "idle_reload_short");

    // Warning band, cleared in PAUSE; resign honoured in PAUSE.
    applyStimulus(GA, 1, mk(100, 100, 1, 0, 0, 0, 0, 1), "warn_start");
    for (int i = 1; i <= 50; i++) begin
      applyStimulus(TK, 1, mk(100 - i, 100, 1, 0, 0, 0, wv(100 - i), 1), "warn_count");
    end
    applyStimulus(PS, 1, mk(50, 100, 0, 0, 0, 0, 0, 3), "warn_pause");
    applyStimulus(RA, 1, mk(50, 100, 0, 0, 1, 0, 0, 4), "resign_in_pause");
    applyStimulus(NG, 1, mk(100, 100, 0, 0, 0, 0, 0, 0), "new_game_after_resign");

    // new_game outranks resign.
    applyStimulus(GB, 1, mk(100, 100, 0, 1, 0, 0, 0, 2), "start_b");
    applyStimulus(NG | RB, 1, mk(100, 100, 0, 0, 0, 0, 0, 0), "new_game_over_resign");

    // Asynchronous reset between edges while B runs.
    applyStimulus(GB, 1, mk(100, 100, 0, 1, 0, 0, 0, 2), "start_b_again");
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(TK, 1, mk(100, 100 - i, 0, 1, 0, 0, 0, 2), "count_b_short");
    end
    mode = 1'b1;
    @(negedge clk);
    #2 clr = 1'b0;
    #1 checkOutput(mk(100, 100, 0, 0, 0, 0, 0, 0), "async_reset");
    @(negedge clk);
    #2 clr = 1'b1;
    applyStimulus('0, 1, mk(300, 300, 0, 0, 0, 0, 0, 0), "post_reset_reload");

    // Every expectation must have been consumed.
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
